// File: rtl/uart_pkg.sv
// Shared types for the uart_tx arbiter: FSM state encoding and sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    // Width of an index into n requesters (at least 1 bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester select with optional sticky re-grant of a locked index.
// Latency: purely combinational, result valid in the same cycle as req_i.
// Backpressure: none; the caller decides when to act on the grant.
// Ports: req_i request vector, ptr_i last granted index (search starts at ptr_i+1),
//        lock_i/lock_idx_i sticky grant, any_o some request present,
//        grant_o one-hot grant, grant_idx_o encoded grant.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    input  logic             lock_i,
    input  logic [IW-1:0]    lock_idx_i,
    output logic             any_o,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    grant_idx_o
);

    int cand;

    always_comb begin
        any_o       = |req_i;
        grant_idx_o = '0;
        cand        = 0;
        if (lock_i && req_i[lock_idx_i]) begin
            grant_idx_o = lock_idx_i;
        end else begin
            // Walk offsets from farthest to nearest so the requester closest
            // after ptr_i is the last one written and therefore wins.
            for (int k = N_REQ; k >= 1; k--) begin
                cand = (int'(ptr_i) + k) % N_REQ;
                if (req_i[IW'(cand)]) begin
                    grant_idx_o = IW'(cand);
                end
            end
        end
        grant_o = any_o ? (N_REQ'(1) << grant_idx_o) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte producers with round-robin grant and frame lock.
// Latency: valid sampled in IDLE -> req_ready pulse and data_rdy at the next edge.
// Backpressure: requests are level-held until granted; data_rdy held until tx_busy or timeout.
// Ports: req_valid/lock/data from requesters; req_ready/req_done pulses back to them;
//        tx_data_out/data_rdy_out to uart_tx, tx_busy_in/tx_done_in from uart_tx;
//        grant_idx_out current/last grant; timeout_err_out pulse when uart_tx never starts.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ         = 4,
    parameter  int DATA_BITS     = DATA_BITS_DEF,
    parameter  int GAP_CYCLES    = 16,
    parameter  int START_TIMEOUT = 4096,
    localparam int IW            = idx_w(N_REQ)
) (
    input  logic                       clk_in,
    input  logic                       nrst_in,
    input  logic [N_REQ-1:0]           req_valid_in,
    input  logic [N_REQ-1:0]           req_lock_in,
    input  logic [N_REQ*DATA_BITS-1:0] req_data_in,
    output logic [N_REQ-1:0]           req_ready_out,
    output logic [N_REQ-1:0]           req_done_out,
    output logic [IW-1:0]              grant_idx_out,
    output logic [DATA_BITS-1:0]       tx_data_out,
    output logic                       data_rdy_out,
    input  logic                       tx_busy_in,
    input  logic                       tx_done_in,
    output logic                       timeout_err_out
);

    localparam int TO_W  = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic                 lock_q, lock_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [N_REQ-1:0]     ready_q, ready_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

    logic                 arb_any;
    logic [N_REQ-1:0]     arb_grant;
    logic [IW-1:0]        arb_idx;
    logic [DATA_BITS-1:0] sel_data;

    // grant_idx doubles as the round-robin pointer and the locked index.
    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i       (req_valid_in),
        .ptr_i       (gidx_q),
        .lock_i      (lock_q),
        .lock_idx_i  (gidx_q),
        .any_o       (arb_any),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_data = req_data_in[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        lock_d    = lock_q;
        tx_data_d = tx_data_q;
        ready_d   = '0;
        done_d    = '0;
        tmo_d     = 1'b0;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            IDLE: begin
                // The lock only survives while its owner keeps asking.
                lock_d = lock_q && req_valid_in[gidx_q];
                if (arb_any) begin
                    gidx_d    = arb_idx;
                    ready_d   = arb_grant;
                    tx_data_d = sel_data;
                    to_cnt_d  = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                // Busy wins over a coincident done; done is only honoured in SEND.
                if (tx_busy_in) begin
                    state_d = SEND;
                end else if (to_cnt_q == TO_LAST) begin
                    tmo_d   = 1'b1;
                    lock_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (tx_done_in) begin
                    done_d[gidx_q] = 1'b1;
                    lock_d         = req_lock_in[gidx_q];
                    gap_cnt_d      = '0;
                    state_d        = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q   <= IDLE;
            gidx_q    <= '0;
            lock_q    <= 1'b0;
            tx_data_q <= '0;
            ready_q   <= '0;
            done_q    <= '0;
            tmo_q     <= 1'b0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gidx_q    <= gidx_d;
            lock_q    <= lock_d;
            tx_data_q <= tx_data_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign req_ready_out   = ready_q;
    assign req_done_out    = done_q;
    assign grant_idx_out   = gidx_q;
    assign tx_data_out     = tx_data_q;
    assign data_rdy_out    = (state_q == LOAD);
    assign timeout_err_out = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a simple uart_tx model and a grant scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int DB       = 8;
    localparam int GAP      = 16;
    localparam int TMO      = 32;
    localparam int BYTE_CYC = 10;

    logic          clk  = 1'b0;
    logic          nrst = 1'b1;
    logic [N-1:0]  req_valid, req_lock;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]  req_ready, req_done;
    logic [1:0]    grant_idx;
    logic [DB-1:0] tx_data;
    logic          data_rdy, tx_busy, tx_done, tmo_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DB), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
        .clk_in          (clk),
        .nrst_in         (nrst),
        .req_valid_in    (req_valid),
        .req_lock_in     (req_lock),
        .req_data_in     (req_data),
        .req_ready_out   (req_ready),
        .req_done_out    (req_done),
        .grant_idx_out   (grant_idx),
        .tx_data_out     (tx_data),
        .data_rdy_out    (data_rdy),
        .tx_busy_in      (tx_busy),
        .tx_done_in      (tx_done),
        .timeout_err_out (tmo_err)
    );

    typedef struct packed {
        logic [1:0]    idx;
        logic [DB-1:0] dat;
    } exp_t;

    typedef struct {
        logic [N-1:0] mask;
        logic [7:0]   base;
        int           n;
        int           ord [4];
    } vec_t;

    exp_t          sb [$];
    logic [DB-1:0] bq [N][$];
    logic [N-1:0]  lock_mode = '0;
    logic          model_en  = 1'b1;

    int checks = 0, errors = 0;
    int cyc = 0, busy_left = 0;
    int ready_cnt = 0, ready_cyc = 0, done_total = 0, tmo_cnt = 0, tmo_cyc = 0, done_set_cyc = 0;
    int done_cnt [N] = '{0, 0, 0, 0};
    logic [N-1:0] ready_vec = '0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expect_tx(input int idx, input int dat);
        exp_t e;
        e.idx = 2'(idx);
        e.dat = 8'(dat);
        sb.push_back(e);
    endtask

    function automatic bit queues_busy();
        bit b = 1'b0;
        for (int i = 0; i < N; i++) if (bq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] m, input logic [7:0] b, input int n,
                                input int o0, input int o1, input int o2, input int o3);
        vec_t v;
        v.mask = m; v.base = b; v.n = n;
        v.ord[0] = o0; v.ord[1] = o1; v.ord[2] = o2; v.ord[3] = o3;
        return v;
    endfunction

    // Monitor, uart_tx model and requester driver share one process so their
    // ordering within a cycle is fixed.
    initial begin
        exp_t e;
        tx_busy = 1'b0; tx_done = 1'b0;
        req_valid = '0; req_lock = '0; req_data = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            tx_done = 1'b0;
            if (!nrst) begin
                tx_busy   = 1'b0;
                busy_left = 0;
            end else begin
                if (req_ready != '0) begin
                    check("ready_onehot", int'($onehot(req_ready)), 1);
                    ready_cnt++; ready_cyc = cyc; ready_vec = req_ready;
                    for (int i = 0; i < N; i++) begin
                        if (req_ready[i]) begin
                            check("ready_has_byte", int'(bq[i].size() > 0), 1);
                            if (bq[i].size() > 0) void'(bq[i].pop_front());
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (req_done[i]) begin
                        done_cnt[i]++; done_total++;
                    end
                end
                if (tmo_err) begin
                    tmo_cnt++; tmo_cyc = cyc;
                end
                if (model_en) begin
                    if (tx_busy) begin
                        if (busy_left == BYTE_CYC) check("rdy_drop_after_busy", int'(data_rdy), 0);
                        busy_left--;
                        if (busy_left == 0) begin
                            tx_busy = 1'b0; tx_done = 1'b1; done_set_cyc = cyc;
                        end
                    end else if (data_rdy) begin
                        if (sb.size() == 0) begin
                            check("unexpected_byte", int'(tx_data), -1);
                        end else begin
                            e = sb.pop_front();
                            check("tx_grant", int'(grant_idx), int'(e.idx));
                            check("tx_data", int'(tx_data), int'(e.dat));
                        end
                        tx_busy = 1'b1; busy_left = BYTE_CYC;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                req_valid[i]         = bq[i].size() > 0;
                req_data[i*DB +: DB] = (bq[i].size() > 0) ? bq[i][0] : 8'h00;
                req_lock[i]          = lock_mode[i];
            end
        end
    end

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((sb.size() != 0 || queues_busy() || tx_busy) && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        check({nm, "_drain"}, int'(n < 2000), 1);
        repeat (GAP + 4) @(posedge clk);
        #2;
    endtask

    task automatic wait_count(input string nm, input int which, input int target);
        int n = 0;
        int cur = 0;
        do begin
            @(posedge clk); #2;
            n++;
            cur = (which == 0) ? ready_cnt : (which == 1) ? done_total : tmo_cnt;
        end while (cur < target && n < 1000);
        check({nm, "_wait"}, int'(cur >= target), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        int   r0, r1, t0, dt0, dsc, dc;
        tbl[0] = mk(4'b1111, 8'h10, 4, 1, 2, 3, 0);
        tbl[1] = mk(4'b0101, 8'h20, 2, 2, 0, 0, 0);
        tbl[2] = mk(4'b1010, 8'h30, 2, 1, 3, 0, 0);
        tbl[3] = mk(4'b1001, 8'h40, 2, 0, 3, 0, 0);
        tbl[4] = mk(4'b0110, 8'h50, 2, 1, 2, 0, 0);
        tbl[5] = mk(4'b1011, 8'h60, 3, 3, 0, 1, 0);

        // Reset values
        #1 nrst = 1'b0;
        #2;
        check("rst_ready", int'(req_ready), 0);
        check("rst_done", int'(req_done), 0);
        check("rst_grant", int'(grant_idx), 0);
        check("rst_txdata", int'(tx_data), 0);
        check("rst_data_rdy", int'(data_rdy), 0);
        check("rst_timeout", int'(tmo_err), 0);
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;

        // Single requester, latency
        dc = done_cnt[0];
        expect_tx(0, 8'hA5);
        bq[0].push_back(8'hA5);
        @(posedge clk); #2;
        check("single_ready_not_early", int'(req_ready), 0);
        @(posedge clk); #2;
        check("single_ready", int'(req_ready), 4'b0001);
        check("single_data_rdy", int'(data_rdy), 1);
        check("single_txdata", int'(tx_data), 8'hA5);
        check("single_grant", int'(grant_idx), 0);
        @(posedge clk); #2;
        check("single_ready_pulse", int'(req_ready), 0);
        wait_drain("single");
        check("single_done", done_cnt[0] - dc, 1);

        // Round-robin vectors
        for (int v = 0; v < 6; v++) begin
            dt0 = done_total;
            for (int j = 0; j < tbl[v].n; j++) expect_tx(tbl[v].ord[j], tbl[v].base + tbl[v].ord[j]);
            for (int i = 0; i < N; i++) if (tbl[v].mask[i]) bq[i].push_back(8'(tbl[v].base + i));
            wait_drain($sformatf("rr%0d", v));
            check($sformatf("rr%0d_done", v), done_total - dt0, tbl[v].n);
        end

        // Frame lock: requester 2 keeps the grant for three bytes
        lock_mode = 4'b0100;
        expect_tx(2, 8'h01); expect_tx(2, 8'h02); expect_tx(2, 8'h03);
        expect_tx(0, 8'h80); expect_tx(1, 8'h81);
        bq[2].push_back(8'h01); bq[2].push_back(8'h02); bq[2].push_back(8'h03);
        bq[0].push_back(8'h80); bq[1].push_back(8'h81);
        wait_drain("lock");
        lock_mode = '0;

        // Inter-byte gap
        r0 = ready_cnt; dt0 = done_total;
        expect_tx(1, 8'hC1); expect_tx(1, 8'hC2);
        bq[1].push_back(8'hC1); bq[1].push_back(8'hC2);
        wait_count("gap_done1", 1, dt0 + 1);
        dsc = done_set_cyc;
        wait_count("gap_ready2", 0, r0 + 2);
        check("gap_cycles", ready_cyc - dsc, GAP + 2);
        wait_drain("gap");

        // Start timeout: uart never goes busy for requester 2
        model_en = 1'b0;
        r0 = ready_cnt; t0 = tmo_cnt; dc = done_cnt[2];
        expect_tx(3, 8'h9A);
        bq[2].push_back(8'h99); bq[3].push_back(8'h9A);
        wait_count("tmo_ready1", 0, r0 + 1);
        check("tmo_first_grant", int'(ready_vec), 4'b0100);
        r1 = ready_cyc;
        wait_count("tmo_pulse", 2, t0 + 1);
        check("tmo_cycles", tmo_cyc - r1, TMO);
        check("tmo_data_rdy_low", int'(data_rdy), 0);
        wait_count("tmo_ready2", 0, r0 + 2);
        check("tmo_next_grant", int'(ready_vec), 4'b1000);
        check("tmo_next_latency", ready_cyc - tmo_cyc, 1);
        model_en = 1'b1;
        wait_drain("tmo");
        check("tmo_no_done", done_cnt[2] - dc, 0);
        check("tmo_count", tmo_cnt - t0, 1);

        // Reset during SEND
        dc = done_cnt[2];
        expect_tx(2, 8'h3C);
        bq[2].push_back(8'h3C);
        wait_count("rst_ready", 0, ready_cnt + 1);
        repeat (3) @(posedge clk);
        #2;
        expect_tx(1, 8'hD1); expect_tx(0, 8'hA0);
        bq[0].push_back(8'hA0); bq[1].push_back(8'hD1);
        check("pre_rst_grant", int'(grant_idx), 2);
        check("pre_rst_txdata", int'(tx_data), 8'h3C);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_grant", int'(grant_idx), 0);
        check("async_rst_txdata", int'(tx_data), 0);
        check("async_rst_outs", int'({req_ready, req_done, data_rdy, tmo_err}), 0);
        @(posedge clk); @(posedge clk); #2;
        nrst = 1'b1;
        wait_drain("rst");
        check("rst_no_done", done_cnt[2] - dc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
